prog_mem_loader: RTL and testbench

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader_pkg.sv | 15 +
 rtl/prog_mem_loader_if.sv | 27 ++
 rtl/prog_mem_array.sv | 25 ++
 rtl/prog_mem_loader.sv | 112 +++++++++++
 tb/tb_prog_mem_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_mem_loader_pkg.sv
// Shared CPU-side definitions for the program-memory loader: FSM state type
// and the bytes-per-word derivation used to size byte assembly.
package prog_mem_loader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } ld_state_e;

  // Number of load bytes needed to cover one instruction word.
  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Fetch port plus byte-load stream of the program memory, bundled for the
// CPU/loader side (master) and the memory block (slave).
interface prog_mem_loader_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]  addr;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   stall;
  logic                   ld_start;
  logic [7:0]             ld_data;
  logic                   ld_valid;
  logic                   ld_ready;
  logic                   ld_done;

  // A byte transfers on a rising edge where ld_valid && ld_ready; ld_data is
  // ignored on every other edge, and ld_valid carries no meaning while ld_ready is low.
  modport master (
    output addr, ld_start, ld_data, ld_valid,
    input  instr, stall, ld_ready, ld_done
  );

  modport slave (
    input  addr, ld_start, ld_data, ld_valid,
    output instr, stall, ld_ready, ld_done
  );
endinterface

// File: rtl/prog_mem_array.sv
// Program storage: asynchronous read for single-cycle fetch, synchronous
// write from the loader; contents survive reset.
module prog_mem_array #(
  parameter int    ADDR_WIDTH = 4,
  parameter int    WIDTH      = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with an in-system byte loader: a full image is streamed in
// little-endian bytes and written word by word while the CPU is stalled.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 4,
  parameter int    INSTR_WIDTH = 12,
  parameter string INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   reset,
  prog_mem_loader_if.slave       bus,
  output ld_state_e              fsm_state
);
  localparam int BPW   = bytes_per_word(INSTR_WIDTH);
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int ASM_W = (BPW > 1) ? (BPW - 1) * 8 : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BPW - 1);

  ld_state_e             state_q, state_n;
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [BC_W-1:0]       bcnt_q;
  logic [ASM_W-1:0]      asm_q;
  logic [BPW*8-1:0]      word_full;
  logic                  done_q;
  logic                  ready;
  logic                  accept;
  logic                  last_byte;
  logic                  last_word;
  logic                  we;

  assign last_byte = (bcnt_q == LAST_BYTE);
  assign last_word = &wptr_q;
  assign we        = accept && last_byte;

  always_comb begin
    state_n = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld_start) state_n = LOAD;
      end
      LOAD: begin
        ready  = 1'b1;
        accept = bus.ld_valid;
        if (accept && last_byte && last_word) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The final byte lands directly in the write data, so the word is stored
  // on the same edge that accepts it.
  generate
    if (BPW > 1) begin : g_multi
      assign word_full = {bus.ld_data, asm_q};
    end else begin : g_single
      logic unused_asm;
      assign word_full  = bus.ld_data;
      assign unused_asm = ^asm_q;
    end
    if (BPW * 8 > INSTR_WIDTH) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^word_full[BPW*8-1:INSTR_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      done_q  <= we && last_word;
      if (state_q == IDLE && bus.ld_start) begin
        wptr_q <= '0;
        bcnt_q <= '0;
      end else if (accept) begin
        if (last_byte) begin
          bcnt_q <= '0;
          wptr_q <= wptr_q + ADDR_WIDTH'(1);
        end else begin
          asm_q[bcnt_q*8 +: 8] <= bus.ld_data;
          bcnt_q               <= bcnt_q + BC_W'(1);
        end
      end
    end
  end

  assign bus.ld_ready = ready;
  assign bus.stall    = ready;
  assign bus.ld_done  = done_q;
  assign fsm_state    = state_q;

  prog_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (INSTR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (word_full[INSTR_WIDTH-1:0]),
    .raddr (bus.addr),
    .rdata (bus.instr)
  );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: the driver streams images and queues
// expected observations; a negedge monitor pops and compares them.
module tb_prog_mem_loader;
  import prog_mem_loader_pkg::*;

  localparam int AW     = 4;
  localparam int IW     = 12;
  localparam int DEPTH  = 16;
  localparam int NBYTES = 32;

  // ---------------- clock / reset ----------------
  logic      clk   = 1'b0;
  logic      reset = 1'b1;
  ld_state_e fsm_state;
  int        cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_mem_loader_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  prog_mem_loader #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- reference model ----------------
  logic [IW-1:0] model [DEPTH];
  logic [7:0]    img   [NBYTES];

  function automatic logic [IW-1:0] word_of(input logic [7:0] lo, input logic [7:0] hi);
    logic [15:0] w;
    w = {hi, lo};
    return w[IW-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int          due_q [$];
  int          sel_q [$];
  int          done_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cur_run  = 0;
  int          last_run = 0;
  bit          end_req  = 1'b0;
  bit          end_done = 1'b0;

  function automatic string sel_name(input int s);
    case (s)
      0:       return "instr";
      1:       return "stall";
      2:       return "ld_ready";
      3:       return "ld_done";
      4:       return "state";
      5:       return "stall_run";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int s);
    case (s)
      0:       return 32'(bus.instr);
      1:       return 32'(bus.stall);
      2:       return 32'(bus.ld_ready);
      3:       return 32'(bus.ld_done);
      4:       return 32'(fsm_state);
      5:       return 32'(last_run);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    int          d;
    int          s;
    logic [31:0] e;
    if (bus.stall === 1'b1) cur_run++;
    else if (cur_run != 0) begin
      last_run = cur_run;
      cur_run  = 0;
    end
    if (bus.ld_done === 1'b1) begin
      if (done_q.size() == 0) chk("ld_done_spurious", 32'd1, 32'd0);
      else chk("ld_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
    end
    while (done_q.size() != 0 && done_q[0] < cyc) begin
      void'(done_q.pop_front());
      chk("ld_done_missing", 32'd0, 32'd1);
    end
    while (due_q.size() != 0 && due_q[0] <= cyc) begin
      d = due_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      if (d < cyc) chk({sel_name(s), "_stale"}, 32'(d), 32'(cyc));
      else chk($sformatf("%s@addr%0d", sel_name(s), bus.addr), observe(s), e);
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("done_q_drained", 32'(done_q.size()), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int s, input logic [31:0] v);
    due_q.push_back(cyc);
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic expect_idle();
    expect_at(1, 32'd0);
    expect_at(2, 32'd0);
    expect_at(4, 32'(IDLE));
  endtask

  task automatic read_word(input int a);
    bus.addr = AW'(a);
    expect_at(0, 32'(model[a]));
    tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) read_word(a);
  endtask

  task automatic new_image(input bit dflt);
    for (int i = 0; i < NBYTES; i++) begin
      if (dflt) img[i] = (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'h00;
      else      img[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    expect_at(1, 32'd1);
    expect_at(2, 32'd1);
    expect_at(4, 32'(LOAD));
  endtask

  task automatic load_bytes(input int n, input bit gaps, input int start_at, input bit fetch_chk);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          bus.ld_valid = 1'b0;
          bus.ld_data  = 8'($urandom);
          tick();
        end
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = img[i];
      bus.ld_start = (i == start_at);
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_start = 1'b0;
      bus.ld_data  = 8'($urandom);
      if (i % 2 == 1) model[i / 2] = word_of(img[i - 1], img[i]);
      if (i == NBYTES - 1) done_q.push_back(cyc);
      if (fetch_chk && i == 1) begin
        bus.addr = '0;
        expect_at(0, 32'(model[0]));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.addr     = '0;
    bus.ld_start = 1'b0;
    bus.ld_data  = '0;
    bus.ld_valid = 1'b0;
    reset        = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    expect_idle();
    expect_at(3, 32'd0);
    tick();

    // full load of the default image, continuous valid, fetch of word 0 mid-load
    new_image(1'b1);
    start_load();
    load_bytes(NBYTES, 1'b0, -1, 1'b1);
    expect_at(5, 32'd32);
    expect_at(1, 32'd0);
    tick();
    read_all();

    // ld_valid while idle must neither start a load nor write memory
    for (int k = 0; k < 5; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'($urandom);
      expect_at(1, 32'd0);
      expect_at(4, 32'(IDLE));
      tick();
    end
    bus.ld_valid = 1'b0;
    read_all();

    // random image with valid gaps, word 5 exercising high-bit truncation
    new_image(1'b0);
    img[10] = 8'h34;
    img[11] = 8'hFF;
    start_load();
    load_bytes(NBYTES, 1'b1, -1, 1'b0);
    tick();
    read_all();
    bus.addr = AW'(5);
    expect_at(0, 32'h0000_0F34);
    tick();

    // ld_start pulsed with byte 10 is ignored
    new_image(1'b0);
    start_load();
    load_bytes(NBYTES, 1'b0, 9, 1'b0);
    expect_at(5, 32'd32);
    tick();
    read_all();

    // back-to-back: new load requested in the ld_done cycle
    new_image(1'b0);
    start_load();
    load_bytes(NBYTES, 1'b1, -1, 1'b0);
    new_image(1'b0);
    start_load();
    load_bytes(NBYTES, 1'b1, -1, 1'b0);
    tick();
    read_all();

    // reset after byte 7: words 0..2 rewritten, word 3 keeps its old value
    new_image(1'b0);
    start_load();
    load_bytes(7, 1'b0, -1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_idle();
    tick();
    read_all();

    // clean load after the abort
    new_image(1'b0);
    start_load();
    load_bytes(NBYTES, 1'b1, -1, 1'b0);
    tick();
    read_all();

    end_req = 1'b1;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
